router_crossbar: RTL and testbench

//  P x P flit switch of a ProNoC-style virtual-channel router, placed after the input ports and the VC/switch allocator.

---
 rtl/router_crossbar.sv | 119 +++++++++++
 tb/tb_router_crossbar.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/router_crossbar.sv
// P x P flit crossbar for a virtual-channel router: routes each granted input flit to its
// target output, with an optional static-straight bypass and an optional output register.
module router_crossbar #(
    parameter int    V                         = 4,
    parameter int    P                         = 5,
    parameter int    Fpay                      = 32,
    parameter string MUX_TYPE                  = "ONE_HOT",
    parameter int    ADD_PIPREG_AFTER_CROSSBAR = 0,
    parameter string SSA_EN                    = "YES"
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [P*(P-1)-1:0]        granted_dest_port_all,
    input  logic [P*(2+V+Fpay)-1:0]   flit_in_all,
    input  logic [P-1:0]              ssa_flit_wr_all,
    output logic [P*(2+V+Fpay)-1:0]   flit_out_all,
    output logic [P-1:0]              flit_out_we_all
);

    localparam int Fw = 2 + V + Fpay;
    localparam int SW = (P > 1) ? $clog2(P) : 1;

    logic [Fw-1:0]   w_flit [P];
    logic [P*Fw-1:0] w_dataAll;
    logic [P-1:0]    w_weAll;

    for (genvar gi = 0; gi < P; gi++) begin : g_flit
        assign w_flit[gi] = flit_in_all[gi*Fw +: Fw];
    end

    for (genvar go = 0; go < P; go++) begin : g_out
        // Straight-through partner for this output: 1<->3, 2<->4.
        localparam int SRC = ((go + 1) % 4) + 1;
        localparam logic [P-1:0] SSA_MASK = (SRC < P) ? (P'(1) << SRC) : '0;

        logic [P-1:0]  w_row;
        logic [P-1:0]  w_sel;
        logic          w_anyGrant;
        logic          w_ssaHit;
        logic [Fw-1:0] w_andOr;
        logic [Fw-1:0] w_data;

        // Input gi's grant field skips itself, so bits at or above gi shift up by one output.
        for (genvar gi = 0; gi < P; gi++) begin : g_in
            if (gi == go) begin : g_self
                assign w_row[gi] = 1'b0;
            end else if (gi < go) begin : g_below
                assign w_row[gi] = granted_dest_port_all[gi*(P-1) + go - 1];
            end else begin : g_above
                assign w_row[gi] = granted_dest_port_all[gi*(P-1) + go];
            end
        end

        if (SSA_EN == "YES" && go >= 1 && SRC < P && SRC != go) begin : g_ssa
            assign w_ssaHit = ssa_flit_wr_all[go];
        end else begin : g_noSsa
            assign w_ssaHit = 1'b0;
        end

        assign w_anyGrant = |w_row;
        assign w_sel      = w_anyGrant ? w_row : (w_ssaHit ? SSA_MASK : '0);

        always_comb begin
            w_andOr = '0;
            for (int i = 0; i < P; i++) begin
                w_andOr = w_andOr | (w_flit[i] & {Fw{w_sel[i]}});
            end
        end

        if (MUX_TYPE == "BINARY") begin : g_bin
            logic [SW-1:0] w_idx;

            always_comb begin
                w_idx = '0;
                for (int i = P - 1; i >= 0; i--) begin
                    if (w_sel[i]) begin
                        w_idx = SW'(i);
                    end
                end
            end

            // Colliding grants fall back to the OR so both mux styles stay bit-identical.
            assign w_data = (w_sel == '0) ? '0 :
                            ($onehot(w_sel) ? w_flit[w_idx] : w_andOr);
        end else begin : g_oneHot
            assign w_data = w_andOr;
        end

        assign w_dataAll[go*Fw +: Fw] = w_data;
        assign w_weAll[go]            = w_anyGrant | w_ssaHit;
    end

    if (ADD_PIPREG_AFTER_CROSSBAR != 0) begin : g_pipe
        logic [P*Fw-1:0] r_data;
        logic [P-1:0]    r_we;
        logic            w_unusedSsa;

        always_ff @(posedge clk) begin
            if (!reset) begin
                r_data <= '0;
                r_we   <= '0;
            end else begin
                r_data <= w_dataAll;
                r_we   <= w_weAll;
            end
        end

        assign w_unusedSsa     = ^ssa_flit_wr_all;
        assign flit_out_all    = r_data;
        assign flit_out_we_all = r_we;
    end else begin : g_comb
        logic w_unusedCtl;

        assign w_unusedCtl     = ^{clk, reset, ssa_flit_wr_all};
        assign flit_out_all    = w_dataAll;
        assign flit_out_we_all = w_weAll;
    end

endmodule

// File: tb/tb_router_crossbar.sv
// Scoreboard bench for router_crossbar: four variants (one-hot, binary, pipelined, SSA off)
// share one stimulus stream; expectations are queued and popped by a monitor.
module tb_router_crossbar;

    localparam int V    = 4;
    localparam int P    = 5;
    localparam int Fpay = 32;
    localparam int Fw   = 2 + V + Fpay;
    localparam int GW   = P * (P - 1);
    localparam int DW   = P * Fw;

    localparam logic [Fw-1:0] F0 = 38'h15_DEAD_BEEF;
    localparam logic [Fw-1:0] F1 = 38'h2A_1234_5678;
    localparam logic [Fw-1:0] F2 = 38'h3F_CAFE_F00D;
    localparam logic [Fw-1:0] F3 = 38'h01_0BAD_F00D;
    localparam logic [Fw-1:0] F4 = 38'h22_8765_4321;

    typedef struct {
        int          cyc;
        logic [P-1:0] we;
        logic [DW-1:0] data;
        logic [P-1:0] weNo;
        logic [DW-1:0] dataNo;
    } combExp_t;

    typedef struct {
        int          cyc;
        logic [P-1:0] we;
        logic [DW-1:0] data;
    } pipeExp_t;

    logic          clk;
    logic          reset;
    logic [GW-1:0] grants;
    logic [DW-1:0] flits;
    logic [P-1:0]  ssa;

    logic [DW-1:0] dataA, dataB, dataC, dataD;
    logic [P-1:0]  weA, weB, weC, weD;

    combExp_t qComb[$];
    pipeExp_t qPipe[$];
    combExp_t ce;
    pipeExp_t pe;

    int checks     = 0;
    int errors     = 0;
    int cycleCount = 0;

    router_crossbar #(.V(V), .P(P), .Fpay(Fpay), .MUX_TYPE("ONE_HOT"),
                      .ADD_PIPREG_AFTER_CROSSBAR(0), .SSA_EN("YES")) dutOneHot (
        .clk(clk), .reset(reset), .granted_dest_port_all(grants), .flit_in_all(flits),
        .ssa_flit_wr_all(ssa), .flit_out_all(dataA), .flit_out_we_all(weA));

    router_crossbar #(.V(V), .P(P), .Fpay(Fpay), .MUX_TYPE("BINARY"),
                      .ADD_PIPREG_AFTER_CROSSBAR(0), .SSA_EN("YES")) dutBinary (
        .clk(clk), .reset(reset), .granted_dest_port_all(grants), .flit_in_all(flits),
        .ssa_flit_wr_all(ssa), .flit_out_all(dataB), .flit_out_we_all(weB));

    router_crossbar #(.V(V), .P(P), .Fpay(Fpay), .MUX_TYPE("ONE_HOT"),
                      .ADD_PIPREG_AFTER_CROSSBAR(1), .SSA_EN("YES")) dutPipe (
        .clk(clk), .reset(reset), .granted_dest_port_all(grants), .flit_in_all(flits),
        .ssa_flit_wr_all(ssa), .flit_out_all(dataC), .flit_out_we_all(weC));

    router_crossbar #(.V(V), .P(P), .Fpay(Fpay), .MUX_TYPE("BINARY"),
                      .ADD_PIPREG_AFTER_CROSSBAR(0), .SSA_EN("NO")) dutNoSsa (
        .clk(clk), .reset(reset), .granted_dest_port_all(grants), .flit_in_all(flits),
        .ssa_flit_wr_all(ssa), .flit_out_all(dataD), .flit_out_we_all(weD));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycleCount <= cycleCount + 1;

    function automatic logic [DW-1:0] mk(input logic [Fw-1:0] d0, d1, d2, d3, d4);
        return {d4, d3, d2, d1, d0};
    endfunction

    // Reference crossbar used for the random stream.
    task automatic model(input logic [GW-1:0] g, input logic [DW-1:0] f, input logic [P-1:0] s,
                         input bit ssaOn, output logic [P-1:0] we, output logic [DW-1:0] data);
        we   = '0;
        data = '0;
        for (int o = 0; o < P; o++) begin
            logic [P-1:0] hit;
            hit = '0;
            for (int i = 0; i < P; i++) begin
                if (i != o) begin
                    int j;
                    j = (o < i) ? o : o - 1;
                    if (g[i*(P-1) + j]) hit[i] = 1'b1;
                end
            end
            if (hit != '0) begin
                we[o] = 1'b1;
                for (int i = 0; i < P; i++) begin
                    if (hit[i]) data[o*Fw +: Fw] = data[o*Fw +: Fw] | f[i*Fw +: Fw];
                end
            end else if (ssaOn && o >= 1 && s[o]) begin
                int src;
                src = ((o + 1) % 4) + 1;
                we[o] = 1'b1;
                data[o*Fw +: Fw] = f[src*Fw +: Fw];
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [P-1:0] actWe,
                               input logic [DW-1:0] actData, input logic [P-1:0] expWe,
                               input logic [DW-1:0] expData);
        checks++;
        if (actWe !== expWe || actData !== expData) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d: got we=%b data=%h, expected we=%b data=%h",
                     name, cycleCount, actWe, actData, expWe, expData);
        end
    endtask

    task automatic applyStimulus(input logic rstN, input logic [GW-1:0] g,
                                 input logic [DW-1:0] f, input logic [P-1:0] s,
                                 input logic [P-1:0] expWe, input logic [DW-1:0] expData,
                                 input logic [P-1:0] expWeNo, input logic [DW-1:0] expDataNo);
        combExp_t c;
        pipeExp_t p;
        @(posedge clk);
        #1;
        reset  = rstN;
        grants = g;
        flits  = f;
        ssa    = s;
        c.cyc = cycleCount; c.we = expWe; c.data = expData;
        c.weNo = expWeNo; c.dataNo = expDataNo;
        qComb.push_back(c);
        p.cyc  = cycleCount;
        p.we   = rstN ? expWe : '0;
        p.data = rstN ? expData : '0;
        qPipe.push_back(p);
    endtask

    always @(negedge clk) begin
        while (qComb.size() > 0 && qComb[0].cyc <= cycleCount) begin
            ce = qComb.pop_front();
            checkOutput("onehot", weA, dataA, ce.we, ce.data);
            checkOutput("binary", weB, dataB, ce.we, ce.data);
            checkOutput("ssaOff", weD, dataD, ce.weNo, ce.dataNo);
        end
        while (qPipe.size() > 0 && qPipe[0].cyc < cycleCount) begin
            pe = qPipe.pop_front();
            checkOutput("pipereg", weC, dataC, pe.we, pe.data);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DW-1:0] fl;
        logic [DW-1:0] d2, d3, d4;
        logic [GW-1:0] rg;
        logic [DW-1:0] rf;
        logic [P-1:0]  rs, eWe, eWeNo;
        logic [DW-1:0] eData, eDataNo;

        reset  = 1'b0;
        grants = '0;
        flits  = '0;
        ssa    = '0;
        fl = mk(F0, F1, F2, F3, F4);
        d2 = mk('0, F0, '0, '0, '0);
        d3 = mk(F3, '0, '0, F1, '0);
        d4 = mk(F3, F4, F0, F1, F2);

        // Reset held: pipelined outputs stay zero, combinational ones follow inputs.
        applyStimulus(1'b0, 20'h00001, fl, 5'b00000, 5'b00010, d2, 5'b00010, d2);
        applyStimulus(1'b0, 20'h00000, fl, 5'b00000, '0, '0, '0, '0);

        applyStimulus(1'b1, 20'h00000, fl, 5'b00000, '0, '0, '0, '0);
        applyStimulus(1'b1, 20'h00001, fl, 5'b00000, 5'b00010, d2, 5'b00010, d2);
        applyStimulus(1'b1, 20'h01040, fl, 5'b00000, 5'b01001, d3, 5'b01001, d3);
        applyStimulus(1'b1, 20'h21842, fl, 5'b00000, 5'b11111, d4, 5'b11111, d4);
        applyStimulus(1'b1, 20'h00000, fl, 5'b00010, 5'b00010, mk('0, F3, '0, '0, '0), '0, '0);
        applyStimulus(1'b1, 20'h00000, fl, 5'b00001, '0, '0, '0, '0);
        applyStimulus(1'b1, 20'h00000, fl, 5'b11111, 5'b11110, mk('0, F3, F4, F1, F2), '0, '0);
        applyStimulus(1'b1, 20'h00001, fl, 5'b00010, 5'b00010, d2, 5'b00010, d2);
        applyStimulus(1'b1, 20'h00040, fl, 5'b00010, 5'b01010, mk('0, F3, '0, F1, '0),
                      5'b01000, mk('0, '0, '0, F1, '0));
        applyStimulus(1'b1, 20'h00201, fl, 5'b00000, 5'b00010, mk('0, F0 | F2, '0, '0, '0),
                      5'b00010, mk('0, F0 | F2, '0, '0, '0));

        // Stream, drop the in-flight flit with one reset edge, then resume.
        applyStimulus(1'b1, 20'h00001, fl, 5'b00000, 5'b00010, d2, 5'b00010, d2);
        applyStimulus(1'b1, 20'h01040, fl, 5'b00000, 5'b01001, d3, 5'b01001, d3);
        applyStimulus(1'b1, 20'h21842, fl, 5'b00000, 5'b11111, d4, 5'b11111, d4);
        applyStimulus(1'b0, 20'h21842, fl, 5'b00000, 5'b11111, d4, 5'b11111, d4);
        applyStimulus(1'b1, 20'h00001, fl, 5'b00000, 5'b00010, d2, 5'b00010, d2);
        applyStimulus(1'b1, 20'h00000, fl, 5'b00000, '0, '0, '0, '0);

        for (int n = 0; n < 10000; n++) begin
            rg = '0;
            for (int i = 0; i < P; i++) begin
                int r;
                r = $urandom_range(0, 4);
                if (r < 4) rg[i*(P-1) + r] = 1'b1;
            end
            for (int i = 0; i < P; i++) begin
                rf[i*Fw +: Fw] = Fw'({$urandom(), $urandom()});
            end
            rs = P'($urandom());
            model(rg, rf, rs, 1'b1, eWe, eData);
            model(rg, rf, rs, 1'b0, eWeNo, eDataNo);
            applyStimulus(1'b1, rg, rf, rs, eWe, eData, eWeNo, eDataNo);
        end

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (qComb.size() + qPipe.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0",
                     qComb.size() + qPipe.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
